// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the core
// load/store port and an external loader/debug port.
module dmem_arbiter #(
  parameter int ADDR_SIZE    = 10,
  parameter int DATA_SIZE    = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [ADDR_SIZE-1:0] core_addr,
  input  logic [DATA_SIZE-1:0] core_wdata,
  output logic                 core_stall,
  output logic                 core_rvalid,
  output logic [DATA_SIZE-1:0] core_rdata,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [ADDR_SIZE-1:0] ext_addr,
  input  logic [DATA_SIZE-1:0] ext_wdata,
  output logic                 ext_gnt,
  output logic                 ext_rvalid,
  output logic [DATA_SIZE-1:0] ext_rdata,
  output logic [ADDR_SIZE-1:0] daddr,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic [DATA_SIZE-1:0] ddata_w,
  input  logic [DATA_SIZE-1:0] ddata_r
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {
    PRIO_CORE,
    PRIO_EXT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_EXT
  } owner_t;

  state_t        state;
  owner_t        rd_owner;
  logic [CW-1:0] starve_cnt;

  logic          core_gnt;
  logic          ext_sel;
  logic          ext_denied;
  logic [CW-1:0] cnt_inc;
  logic          go_ext;

  always_comb begin
    core_gnt = 1'b0;
    ext_sel  = 1'b0;
    unique case (state)
      PRIO_CORE: begin
        if (core_req)     core_gnt = 1'b1;
        else if (ext_req) ext_sel  = 1'b1;
      end
      PRIO_EXT: begin
        if (ext_req)       ext_sel  = 1'b1;
        else if (core_req) core_gnt = 1'b1;
      end
      default: begin
        core_gnt = 1'b0;
        ext_sel  = 1'b0;
      end
    endcase
  end

  assign ext_denied = ext_req & ~ext_sel;

  assign cnt_inc = (starve_cnt == LIMIT)
                 ? starve_cnt
                 : starve_cnt + 1'b1;

  // Switch on the denial that brings the count to the limit, so ext
  // gets the very next slot: one ext slot per STARVE_LIMIT+1 cycles.
  assign go_ext = ext_denied & (cnt_inc == LIMIT);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= PRIO_CORE;
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      unique case (state)
        PRIO_CORE: if (go_ext) state <= PRIO_EXT;
        PRIO_EXT:  if (ext_sel || !ext_req) state <= PRIO_CORE;
        default:   state <= PRIO_CORE;
      endcase

      starve_cnt <= ext_denied ? cnt_inc : '0;

      unique case (1'b1)
        core_gnt & ~core_we: rd_owner <= OWN_CORE;
        ext_sel & ~ext_we:   rd_owner <= OWN_EXT;
        default:             rd_owner <= OWN_NONE;
      endcase
    end
  end

  assign core_stall = RESET_N & core_req & ~core_gnt;
  assign ext_gnt    = RESET_N & ext_sel;

  always_comb begin
    daddr    = '0;
    ddata_w  = '0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    if (RESET_N) begin
      unique case (1'b1)
        core_gnt: begin
          daddr    = core_addr;
          ddata_w  = core_wdata;
          MemWrite = core_we;
          MemRead  = ~core_we;
        end
        ext_sel: begin
          daddr    = ext_addr;
          ddata_w  = ext_wdata;
          MemWrite = ext_we;
          MemRead  = ~ext_we;
        end
        default: begin
          daddr    = '0;
          ddata_w  = '0;
          MemWrite = 1'b0;
          MemRead  = 1'b0;
        end
      endcase
    end
  end

  assign core_rvalid = RESET_N & (rd_owner == OWN_CORE);
  assign ext_rvalid  = RESET_N & (rd_owner == OWN_EXT);
  assign core_rdata  = core_rvalid ? ddata_r : '0;
  assign ext_rdata   = ext_rvalid ? ddata_r : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus starvation
// and priority-return sequences against a behavioural RAM.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int OW = 1 + 1 + DW + 1 + 1 + DW + AW + 1 + 1 + DW;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] daddr;
  logic          MemWrite, MemRead;
  logic [DW-1:0] ddata_w;
  logic [DW-1:0] ddata_r;

  always #5 CLK = ~CLK;

  dmem_arbiter #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .STARVE_LIMIT(4)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata),
    .daddr(daddr), .MemWrite(MemWrite), .MemRead(MemRead),
    .ddata_w(ddata_w), .ddata_r(ddata_r)
  );

  // RAM model: unwritten words read as {16'hCAFE, 6'b0, addr}
  logic [DW-1:0] mem [1024];
  bit            written [1024];
  logic [DW-1:0] ram_q = '0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16'hCAFE, 6'b0, a};
  endfunction

  always @(posedge CLK) begin
    if (MemWrite) begin
      mem[daddr]     <= ddata_w;
      written[daddr] <= 1'b1;
    end
    if (MemRead)
      ram_q <= written[daddr] ? mem[daddr] : pat(daddr);
  end
  assign ddata_r = ram_q;

  typedef struct {
    logic          rst;
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          ereq, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic [OW-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(
    input logic rst,
    input logic creq, input logic cwe,
    input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
    input logic ereq, input logic ewe,
    input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd,
    input logic stall, input logic crv, input logic [DW-1:0] crd,
    input logic egnt, input logic erv, input logic [DW-1:0] erd,
    input logic [AW-1:0] da, input logic mw, input logic mr,
    input logic [DW-1:0] dw
  );
    vec_t v;
    v.rst = rst;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.ereq = ereq; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    v.exp = {stall, crv, crd, egnt, erv, erd, da, mw, mr, dw};
    vecs.push_back(v);
  endtask

  function automatic logic [OW-1:0] outs();
    return {core_stall, core_rvalid, core_rdata,
            ext_gnt, ext_rvalid, ext_rdata,
            daddr, MemWrite, MemRead, ddata_w};
  endfunction

  task automatic drive(
    input logic rst,
    input logic creq, input logic cwe,
    input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
    input logic ereq, input logic ewe,
    input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd
  );
    RESET_N = rst;
    core_req = creq; core_we = cwe;
    core_addr = caddr; core_wdata = cwd;
    ext_req = ereq; ext_we = ewe;
    ext_addr = eaddr; ext_wdata = ewd;
  endtask

  task automatic check(
    input string name, input int idx,
    input logic [OW-1:0] got, input logic [OW-1:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h",
               name, idx, got, exp);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset with both requesting: everything quiet
    add(0, 1,0,5,0, 1,1,7,1, 0,0,0, 0,0,0, 0,0,0,0);
    add(0, 1,0,5,0, 1,1,7,1, 0,0,0, 0,0,0, 0,0,0,0);
    // after release core has priority
    add(1, 1,0,5,'h11111111, 1,1,7,1,
        0,0,0, 0,0,0, 5,0,1,'h11111111);
    add(1, 0,0,0,0, 0,0,0,0, 0,1,'hCAFE0005, 0,0,0, 0,0,0,0);
    // core read alone
    add(1, 1,0,5,0, 0,0,0,0, 0,0,0, 0,0,0, 5,0,1,0);
    add(1, 0,0,0,0, 0,0,0,0, 0,1,'hCAFE0005, 0,0,0, 0,0,0,0);
    // ext read 0x3FF then core read 0x001
    add(1, 0,0,0,0, 1,0,'h3FF,0, 0,0,0, 1,0,0, 'h3FF,0,1,0);
    add(1, 1,0,1,0, 0,0,0,0,
        0,0,0, 0,1,'hCAFE03FF, 1,0,1,0);
    add(1, 0,0,0,0, 0,0,0,0, 0,1,'hCAFE0001, 0,0,0, 0,0,0,0);
    // ext write then core reads it back
    add(1, 0,0,0,0, 1,1,'h010,'hDEADBEEF,
        0,0,0, 1,0,0, 'h010,1,0,'hDEADBEEF);
    add(1, 1,0,'h010,0, 0,0,0,0, 0,0,0, 0,0,0, 'h010,0,1,0);
    add(1, 0,0,0,0, 0,0,0,0, 0,1,'hDEADBEEF, 0,0,0, 0,0,0,0);
    // core read, then reset: no rvalid; ext starve count cleared
    add(1, 1,0,2,0, 1,1,'h20,5, 0,0,0, 0,0,0, 2,0,1,0);
    add(0, 1,1,3,7, 1,1,'h21,6, 0,0,0, 0,0,0, 0,0,0,0);
    for (int k = 0; k < 4; k++)
      add(1, 1,1,AW'('h100 + k),DW'('hC0 + k), 1,1,'h200,'hE0,
          0,0,0, 0,0,0, AW'('h100 + k),1,0,DW'('hC0 + k));
    add(1, 1,1,'h104,'hC4, 1,1,'h200,'hE0,
        1,0,0, 1,0,0, 'h200,1,0,'hE0);
    add(1, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK); #1;
      drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe,
            vecs[i].caddr, vecs[i].cwd, vecs[i].ereq,
            vecs[i].ewe, vecs[i].eaddr, vecs[i].ewd);
      @(negedge CLK);
      check("vec", i, outs(), vecs[i].exp);
    end

    // continuous contention: ext slot every 5th cycle
    for (int k = 0; k < 15; k++) begin
      logic e;
      logic [OW-1:0] x;
      e = (k % 5) == 4;
      @(posedge CLK); #1;
      drive(1, 1, 1, AW'('h040 + k), DW'('hA000 + k),
            1, 1, 'h080, DW'('hB000 + k));
      x = {e, 1'b0, 32'h0, e, 1'b0, 32'h0,
           e ? AW'('h080) : AW'('h040 + k), 1'b1, 1'b0,
           e ? DW'('hB000 + k) : DW'('hA000 + k)};
      @(negedge CLK);
      check("starve", k, outs(), x);
    end

    // enter PRIO_EXT, drop ext_req: core served, priority returns
    for (int k = 0; k < 10; k++) begin
      logic e;
      logic er;
      logic [OW-1:0] x;
      e  = (k == 9);
      er = (k != 4);
      @(posedge CLK); #1;
      drive(1, 1, 1, AW'('h300 + k), DW'('h7000 + k),
            er, 1, 'h3F0, DW'('h9000 + k));
      x = {e, 1'b0, 32'h0, e, 1'b0, 32'h0,
           e ? AW'('h3F0) : AW'('h300 + k), 1'b1, 1'b0,
           e ? DW'('h9000 + k) : DW'('h7000 + k)};
      @(negedge CLK);
      check("prio_ret", k, outs(), x);
    end

    @(posedge CLK); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    check("idle", 0, outs(), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
